// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
//   Sequential shift-add-3 (double-dabble) binary to packed BCD converter.
//   Converts one input bit per clock. The result register only updates
//   when a conversion completes, so downstream displays never see
//   partial values.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   start - conversion request, sampled only while idle
//   bin   - unsigned binary value, captured on the accepted start edge
//   busy  - high while a conversion is in progress
//   done  - one-cycle pulse: bcd has just been updated
//   bcd   - packed BCD result, digit i at [4i+3:4i], digit 0 = ones
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    shreg;
    logic [4*DIGITS-1:0] scratch;
    logic [CW-1:0]       count;

    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] next_scratch;
    logic [WIDTH-1:0]    next_shreg;

    // One double-dabble iteration: add 3 to every digit >= 5, then shift
    // {scratch, shreg} left by one with the shreg MSB entering digit 0.
    always_comb begin
        adj = scratch;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
        end
        next_scratch = {adj[4*DIGITS-2:0], shreg[WIDTH-1]};
        next_shreg   = shreg << 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            scratch <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shreg   <= bin;
                        scratch <= '0;
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    scratch <= next_scratch;
                    shreg   <= next_shreg;
                    count   <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        bcd   <= next_scratch;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq
//   Directed bench for bin_to_bcd_seq: an 8-bit/3-digit instance and a
//   4-bit/2-digit instance sharing clock and reset.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0;
    logic [7:0]  bin8 = '0;
    logic        busy8, done8;
    logic [11:0] bcd8;
    logic        start4 = 1'b0;
    logic [3:0]  bin4 = '0;
    logic        busy4, done4;
    logic [7:0]  bcd4;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .bin(bin8),
        .busy(busy8), .done(done8), .bcd(bcd8)
    );

    bin_to_bcd_seq #(.WIDTH(4), .DIGITS(2)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .bin(bin4),
        .busy(busy4), .done(done4), .bcd(bcd4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Decimal digits by division, independent of the shift-add method.
    function automatic logic [31:0] ref_bcd(input int unsigned v);
        logic [31:0] r;
        r = '0;
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic run8(input logic [7:0] v, input string tag);
        int unsigned cycles;
        int unsigned busy_cnt;
        @(negedge clk);
        bin8   = v;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cycles   = 0;
        busy_cnt = 0;
        while (!done8 && cycles < 20) begin
            if (busy8) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        check({tag, "_latency"}, cycles, 8);
        check({tag, "_busy"}, busy_cnt, 8);
        check({tag, "_bcd"}, {20'h0, bcd8}, ref_bcd(v));
        @(negedge clk);
        check({tag, "_done_w"}, {31'h0, done8}, 0);
    endtask

    task automatic run4(input logic [3:0] v);
        int unsigned cycles;
        @(negedge clk);
        bin4   = v;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        cycles = 0;
        while (!done4 && cycles < 12) begin
            @(negedge clk);
            cycles++;
        end
        check("w4_latency", cycles, 4);
        check("w4_bcd", {24'h0, bcd4}, ref_bcd(v));
        @(negedge clk);
    endtask

    initial begin : stim
        int unsigned t0;
        int unsigned t1;
        int unsigned n;
        int unsigned extra;

        // 1: reset state and zero conversion
        repeat (3) @(negedge clk);
        check("rst_busy", {31'h0, busy8}, 0);
        check("rst_done", {31'h0, done8}, 0);
        check("rst_bcd", {20'h0, bcd8}, 0);
        rst = 1'b0;
        @(negedge clk);
        run8(8'd0, "zero");

        // 2: boundary values
        run8(8'd255, "v255");
        check("v255_lit", {20'h0, bcd8}, 32'h255);
        run8(8'd99, "v99");
        check("v99_lit", {20'h0, bcd8}, 32'h099);
        run8(8'd100, "v100");
        check("v100_lit", {20'h0, bcd8}, 32'h100);

        // 3: start held high, back-to-back conversions
        @(negedge clk);
        bin8   = 8'd42;
        start8 = 1'b1;
        n = 0;
        while (!done8 && n < 30) begin @(negedge clk); n++; end
        t0 = n;
        check("b2b_first", {20'h0, bcd8}, 32'h042);
        bin8 = 8'd7;
        @(negedge clk);
        n++;
        while (!done8 && n < 60) begin @(negedge clk); n++; end
        t1 = n;
        start8 = 1'b0;
        check("b2b_second", {20'h0, bcd8}, 32'h007);
        check("b2b_spacing", t1 - t0, 10);
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8 || busy8) extra++;
        end
        check("b2b_no_extra", extra, 0);

        // 4: bin change and start pulse during CONV are ignored; bcd held
        @(negedge clk);
        bin8   = 8'd200;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        extra = 0;
        n = 0;
        while (!done8 && n < 20) begin
            if (n == 2) begin bin8 = 8'd13; start8 = 1'b1; end
            else start8 = 1'b0;
            if (bcd8 !== 12'h007) extra++;
            @(negedge clk);
            n++;
        end
        start8 = 1'b0;
        check("hold_bcd_stable", extra, 0);
        check("hold_result", {20'h0, bcd8}, 32'h200);
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8 || busy8) extra++;
        end
        check("hold_no_extra", extra, 0);

        // 5: asynchronous reset mid-conversion
        @(negedge clk);
        bin8   = 8'd150;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_pre", {31'h0, busy8}, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'h0, busy8}, 0);
        check("abort_done", {31'h0, done8}, 0);
        check("abort_bcd", {20'h0, bcd8}, 0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8 || busy8) extra++;
        end
        check("abort_no_done", extra, 0);
        run8(8'd57, "after_abort");
        check("after_abort_lit", {20'h0, bcd8}, 32'h057);

        // 6: exhaustive sweeps
        for (int v = 0; v < 256; v++) run8(8'(v), "sweep8");
        for (int v = 0; v < 16; v++) run4(4'(v));
        check("w4_15_lit", {24'h0, bcd4}, 32'h15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
